sec32_check_gen: RTL
====================

# sec32_check_gen

Pipelined check-bit generator for the 32-bit single-error-correcting (SEC) datapath. It accepts 32-bit data words over a valid/ready handshake, computes the 8 even-parity check bits expected by the downstream SEC corrector, and presents data, check bits and the corrector enable as one registered beat. It sits directly upstream of the corrector: its m_data/m_check/m_en drive the corrector's 32 data inputs, 8 check inputs and enable input.

## Interface
- CNT_W, 16, width of the accepted-word counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  block can accept a word this cycle
- s_data  in  32  input word, d0 = bit 0
- chk_en  in  1  corrector enable, sampled with each accepted word
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  32  data to corrector
- m_check  out  8  check bits r0..r7 to corrector
- m_en  out  1  corrector enable for this beat
- words_sent  out  CNT_W  count of beats accepted downstream (m_valid & m_ready)
- inj_arm  in  1  arm one-shot error injection (pulse)
- inj_pos  in  6  bit to flip: 0–31 data bit, 32–39 check bit r(pos-32), 40–63 no flip
- inj_busy  out  1  injection armed, not yet applied

## Operation
- Check-bit groups (r_k = XOR of listed data bits, even parity):
  - r0: d0,d4,d8,d12,d16–d23
  - r1: d1,d5,d9,d13,d24–d31
  - r2: d2,d6,d10,d14,d16–d19,d24–d27
  - r3: d3,d7,d11,d15,d20–d23,d28–d31
  - r4: d16,d20,d24,d28,d0–d7
  - r5: d17,d21,d25,d29,d8–d15
  - r6: d18,d22,d26,d30,d0–d3,d8–d11
  - r7: d19,d23,d27,d31,d4–d7,d12–d15
- Stage 1 (S1): registers s_data, chk_en; valid bit v1.
- Stage 2 (S2): registers data, computed check bits, enable, after optional injection; v2 drives m_valid.
- Per-stage ready: S2 loads when !v2 | m_ready; S1 loads when !v1 | S2 loads. s_ready = !v1 | !v2 | m_ready (combinational from m_ready).
- A stage holds its contents unchanged while stalled; no beat is dropped or duplicated.
- words_sent increments by 1 on each m_valid & m_ready; wraps 2^CNT_W−1 → 0.
- Reset: v1=v2=0, m_valid=0, m_data=0, m_check=0, m_en=0, words_sent=0, inj_busy=0, s_ready=1 the cycle after reset deasserts.

## Timing
- Latency: word accepted at edge N appears on m_outputs after edge N+1 (m_valid high in cycle N+1→N+2 window) with m_ready held high.
- Throughput: one word per cycle when m_ready=1 continuously.
- m_ready low with both stages full: s_ready=0; simultaneous m_ready high and s_valid high in that cycle: S2 takes S1, S1 takes new word, no bubble.
- rst asserted mid-stream: all in-flight beats discarded at that edge, injection disarmed, counter cleared.
- m_en, m_data, m_check are register outputs; no combinational path from s_data.

## Configuration
- SEC32_ERR_INJECT_EN defined: inj_arm sets inj_busy (if clear; re-arm while busy ignored, inj_pos latched at arm). Next word moving S1→S2 has bit inj_pos flipped after check computation; inj_busy clears on that same edge. inj_arm and that transfer in the same cycle: arm takes effect for the following transfer.
- Undefined: inj_arm/inj_pos ignored, inj_busy constant 0, no injection logic synthesized.

## Test plan
- s_data=0x00000001, chk_en=1, m_ready=1 → two edges later m_data=0x00000001, m_check=0x51, m_en=1, words_sent=1.
- s_data=0xFFFFFFFF → m_check=0x00; s_data=0x80000000 → m_check=0x8A; back-to-back in consecutive cycles, no bubble.
- Stream 8 words, m_ready low for 5 cycles mid-stream → s_ready drops after both stages fill; all 8 words emerge in order, exactly once; words_sent=8.
- Preload words_sent to 0xFFFE via 65534 beats (or forced), send 3 beats → counter 0xFFFF, 0x0000, 0x0001.
- With SEC32_ERR_INJECT_EN, inj_pos=5, send 0x00000000 → m_data=0x00000020, m_check=0x00, inj_busy 1→0; inj_pos=33 → m_check=0x02; downstream corrector restores 0x00000000.
- Assert rst with both stages full and m_ready=0 → next cycle m_valid=0, m_data=0, words_sent=0, s_ready=1.

Source files
------------

// File: rtl/sec32_check_gen_if.sv
// Stream interface for sec32_check_gen: upstream word channel and downstream beat channel.
// slave is the generator's view, master is the view of whatever drives and drains it.
interface sec32_check_gen_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        chk_en;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [7:0]  m_check;
  logic        m_en;

  modport slave (
    input  s_valid, s_data, chk_en, m_ready,
    output s_ready, m_valid, m_data, m_check, m_en
  );

  modport master (
    output s_valid, s_data, chk_en, m_ready,
    input  s_ready, m_valid, m_data, m_check, m_en
  );
endinterface

// File: rtl/sec32_check_gen.sv
// Two-stage check-bit generator feeding the 32-bit SEC corrector.
// Optional one-shot error injection is compiled in with SEC32_ERR_INJECT_EN.
module sec32_check_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sec32_check_gen_if.slave bus,
  output logic [CNT_W-1:0] words_sent,
  input  logic             inj_arm,
  input  logic [5:0]       inj_pos,
  output logic             inj_busy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and a presented beat is held unchanged until taken.
  logic        v1, v2;
  logic [31:0] d1;
  logic        en1;
  logic [31:0] d2;
  logic [7:0]  c2;
  logic        en2;
  logic        s2_load, s1_load, accept, xfer;
  logic [39:0] flip;
  logic [39:0] beat;

  assign s2_load     = !v2 || bus.m_ready;
  assign s1_load     = !v1 || s2_load;
  assign accept      = bus.s_valid && s1_load;
  assign xfer        = v1 && s2_load;
  assign bus.s_ready = s1_load;

  function automatic logic [7:0] check_bits(input logic [31:0] d);
    logic [7:0] c;
    c[0] = ^(d & 32'h00FF_1111);
    c[1] = ^(d & 32'hFF00_2222);
    c[2] = ^(d & 32'h0F0F_4444);
    c[3] = ^(d & 32'hF0F0_8888);
    c[4] = ^(d & 32'h1111_00FF);
    c[5] = ^(d & 32'h2222_FF00);
    c[6] = ^(d & 32'h4444_0F0F);
    c[7] = ^(d & 32'h8888_F0F0);
    return c;
  endfunction

  // The flip is applied after check computation so the beat carries a real single-bit error.
  assign beat = {check_bits(d1), d1} ^ flip;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      d1  <= '0;
      en1 <= 1'b0;
    end else if (s1_load) begin
      v1 <= bus.s_valid;
      if (accept) begin
        d1  <= bus.s_data;
        en1 <= bus.chk_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      d2  <= '0;
      c2  <= '0;
      en2 <= 1'b0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        d2  <= beat[31:0];
        c2  <= beat[39:32];
        en2 <= en1;
      end
    end
  end

  assign bus.m_valid = v2;
  assign bus.m_data  = d2;
  assign bus.m_check = c2;
  assign bus.m_en    = en2;

  always_ff @(posedge clk) begin
    if (rst)
      words_sent <= '0;
    else if (v2 && bus.m_ready)
      words_sent <= words_sent + 1'b1;
  end

`ifdef SEC32_ERR_INJECT_EN
  logic       busy_q;
  logic [5:0] pos_q;

  always_comb begin
    flip = '0;
    if (busy_q && (pos_q < 6'd40))
      flip[pos_q] = 1'b1;
  end

  // Disarm on the consuming transfer wins over a same-cycle arm, so a new arm waits for the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      pos_q  <= '0;
    end else if (busy_q && xfer) begin
      busy_q <= 1'b0;
    end else if (inj_arm && !busy_q) begin
      busy_q <= 1'b1;
      pos_q  <= inj_pos;
    end
  end

  assign inj_busy = busy_q;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_arm, inj_pos, xfer};
  assign flip       = '0;
  assign inj_busy   = 1'b0;
`endif

endmodule
